reversi_sequencer: RTL and testbench

Top-level game controller for the Reversi design. Issues one-hot enable strobes to the datapath and advances on the datapath's shared `go` completion signal and its `validMove` and `hasTurn` flags. Turns player key presses into cursor moves and placement attempts. Decides on turn passing and game over. Sits between the keyboard/key synchroniser and the datapath.

---
 rtl/reversi_pkg.sv | 27 ++
 rtl/reversi_sequencer_key_edge_detect.sv | 27 ++
 rtl/reversi_sequencer.sv | 170 +++++++++++++++++
 tb/tb_reversi_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reversi_pkg.sv
// reversi_pkg: shared definitions for the Reversi game controller.
//   state_e          - 5-bit game-controller state encoding (also exported on stateOut)
//   K_*              - key bit positions; a lower index means a higher priority
//   TIMEOUT_DEFAULT  - default idle cycles before a turn is forfeited
//   is_wait()        - true for states that hold an enable until the datapath answers go
package reversi_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_DRAW_BOARD, S_DRAW_PIECES, S_HIGHLIGHT, S_IDLE,
    S_MOVE, S_CHECK, S_PLACE, S_FLIP, S_SCORE,
    S_TURN, S_HAS_CUR, S_HAS_OPP, S_REMOVE, S_OVER
  } state_e;

  localparam int KEY_W   = 5;
  localparam int K_ENTER = 0;
  localparam int K_RIGHT = 1;
  localparam int K_LEFT  = 2;
  localparam int K_UP    = 3;
  localparam int K_DOWN  = 4;

  localparam logic [31:0] TIMEOUT_DEFAULT = 32'd1_500_000_000;

  function automatic logic is_wait(input state_e s);
    return !(s inside {S_IDLE, S_MOVE, S_OVER});
  endfunction

endpackage

// File: rtl/reversi_sequencer_key_edge_detect.sv
// key_edge_detect: rising-edge detector over the five player keys with
// priority encoding down to a single one-hot command.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_keys         : synchronised key levels, bit order per reversi_pkg K_*
//   o_cmd          : one-hot rising edge of the highest-priority key (0 if none)
module key_edge_detect
  import reversi_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [KEY_W-1:0] i_keys,
  output logic [KEY_W-1:0] o_cmd
);

  logic [KEY_W-1:0] r_keys;
  logic [KEY_W-1:0] w_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_keys <= '0;
    else          r_keys <= i_keys;
  end

  assign w_rise = i_keys & ~r_keys;
  // Isolate the lowest set bit: lowest index is highest priority.
  assign o_cmd  = w_rise & (~w_rise + 5'd1);

endmodule

// File: rtl/reversi_sequencer.sv
// reversi_sequencer: top-level Reversi game controller. Strobes one datapath
// operation at a time, advances on the shared go flag, turns key presses into
// cursor moves / placement attempts, and decides turn passing and game over.
//   clk, resetn                 : clock, asynchronous active-low reset
//   key*                        : synchronised active-high key levels
//   go, validMove, hasTurn      : datapath completion flag and its results
//   *En                         : one-hot datapath operation enables (registered)
//   determineCurrent/Opponent   : qualifiers for determineHasTurnEn
//   gameOver                    : high in S_OVER
//   stateOut                    : current state, for debug
// Optional feature: define MOVE_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES idle cycles in S_IDLE.
module reversi_sequencer
  import reversi_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       keyEnter,
  input  logic       keyRight,
  input  logic       keyLeft,
  input  logic       keyUp,
  input  logic       keyDown,
  input  logic       go,
  input  logic       validMove,
  input  logic       hasTurn,
  output logic       resetEn,
  output logic       drawBoardEn,
  output logic       drawInitialPiecesEn,
  output logic       moveHighlightEn,
  output logic       checkIfValidMoveEn,
  output logic       placeEn,
  output logic       flipEn,
  output logic       scoreManagerEn,
  output logic       determineHasTurnEn,
  output logic       TurnManagerEn,
  output logic       removeHighlightEn,
  output logic       moveRightEn,
  output logic       moveLeftEn,
  output logic       moveUpEn,
  output logic       moveDownEn,
  output logic       determineCurrent,
  output logic       determineOpponent,
  output logic       gameOver,
  output logic [4:0] stateOut
);

  state_e           r_state, w_next;
  logic             r_entry;     // first cycle of the current state
  logic             w_go_q;      // go qualified past the entry cycle
  logic [KEY_W-1:0] w_keys, w_cmd;
  logic             w_key_hit;   // a key edge accepted in S_IDLE
  logic             w_tmo_hit;

  assign w_keys = {keyDown, keyUp, keyLeft, keyRight, keyEnter};

  key_edge_detect u_keys (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_keys  (w_keys),
    .o_cmd   (w_cmd)
  );

  // go may still be the previous operation's done flag on entry.
  assign w_go_q    = go & ~r_entry & is_wait(r_state);
  assign w_key_hit = (r_state == S_IDLE) && (|w_cmd);

`ifdef MOVE_TIMEOUT_EN
  logic [31:0] r_tmo;

  // A key edge in the expiry cycle takes precedence over the forfeit.
  assign w_tmo_hit = (r_state == S_IDLE) && !w_key_hit &&
                     (r_tmo == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                              r_tmo <= '0;
    else if (r_state == S_IDLE && !w_key_hit && !w_tmo_hit)   r_tmo <= r_tmo + 32'd1;
    else                                                      r_tmo <= '0;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_RESET;
      r_entry <= 1'b1;
    end else begin
      r_state <= w_next;
      r_entry <= (w_next != r_state);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:       if (w_go_q) w_next = S_DRAW_BOARD;
      S_DRAW_BOARD:  if (w_go_q) w_next = S_DRAW_PIECES;
      S_DRAW_PIECES: if (w_go_q) w_next = S_HIGHLIGHT;
      S_HIGHLIGHT:   if (w_go_q) w_next = S_IDLE;
      S_IDLE: begin
        if (w_cmd[K_ENTER])  w_next = S_CHECK;
        else if (|w_cmd)     w_next = S_MOVE;
        else if (w_tmo_hit)  w_next = S_TURN;
      end
      S_MOVE:        w_next = S_HIGHLIGHT;
      S_CHECK:       if (w_go_q) w_next = validMove ? S_PLACE : S_IDLE;
      S_PLACE:       if (w_go_q) w_next = S_FLIP;
      S_FLIP:        if (w_go_q) w_next = S_SCORE;
      S_SCORE:       if (w_go_q) w_next = S_TURN;
      S_TURN:        if (w_go_q) w_next = S_HAS_CUR;
      S_HAS_CUR:     if (w_go_q) w_next = hasTurn ? S_HIGHLIGHT : S_HAS_OPP;
      // Opponent can move: pass the turn back through S_TURN.
      S_HAS_OPP:     if (w_go_q) w_next = hasTurn ? S_TURN : S_REMOVE;
      S_REMOVE:      if (w_go_q) w_next = S_OVER;
      S_OVER:        w_next = S_OVER;
      default:       w_next = S_RESET;
    endcase
  end

  // Outputs decode the next state so each enable rises with state entry.
  // S_MOVE is only reached from S_IDLE, so w_cmd still names the direction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resetEn             <= 1'b1;
      drawBoardEn         <= 1'b0;
      drawInitialPiecesEn <= 1'b0;
      moveHighlightEn     <= 1'b0;
      checkIfValidMoveEn  <= 1'b0;
      placeEn             <= 1'b0;
      flipEn              <= 1'b0;
      scoreManagerEn      <= 1'b0;
      determineHasTurnEn  <= 1'b0;
      TurnManagerEn       <= 1'b0;
      removeHighlightEn   <= 1'b0;
      moveRightEn         <= 1'b0;
      moveLeftEn          <= 1'b0;
      moveUpEn            <= 1'b0;
      moveDownEn          <= 1'b0;
      determineCurrent    <= 1'b0;
      determineOpponent   <= 1'b0;
      gameOver            <= 1'b0;
    end else begin
      resetEn             <= (w_next == S_RESET);
      drawBoardEn         <= (w_next == S_DRAW_BOARD);
      drawInitialPiecesEn <= (w_next == S_DRAW_PIECES);
      moveHighlightEn     <= (w_next == S_HIGHLIGHT);
      checkIfValidMoveEn  <= (w_next == S_CHECK);
      placeEn             <= (w_next == S_PLACE);
      flipEn              <= (w_next == S_FLIP);
      scoreManagerEn      <= (w_next == S_SCORE);
      determineHasTurnEn  <= (w_next == S_HAS_CUR) || (w_next == S_HAS_OPP);
      TurnManagerEn       <= (w_next == S_TURN);
      removeHighlightEn   <= (w_next == S_REMOVE);
      moveRightEn         <= (w_next == S_MOVE) && w_cmd[K_RIGHT];
      moveLeftEn          <= (w_next == S_MOVE) && w_cmd[K_LEFT];
      moveUpEn            <= (w_next == S_MOVE) && w_cmd[K_UP];
      moveDownEn          <= (w_next == S_MOVE) && w_cmd[K_DOWN];
      determineCurrent    <= (w_next == S_HAS_CUR);
      determineOpponent   <= (w_next == S_HAS_OPP);
      gameOver            <= (w_next == S_OVER);
    end
  end

  assign stateOut = r_state;

endmodule

// File: tb/tb_reversi_sequencer.sv
// tb_reversi_sequencer: directed and randomized checks of reversi_sequencer.
// The bench plays the datapath (answering go after a random delay) and the
// player (pressing keys), and predicts the sequence of operations from the
// game rules. Build with MOVE_TIMEOUT_EN defined to add the forfeit checks.
module tb_reversi_sequencer;

  // Operation ids observed on the outputs.
  localparam int OP_NONE = -1, OP_RST = 0, OP_BOARD = 1, OP_PIECES = 2, OP_HL = 3,
                 OP_CHECK = 4, OP_PLACE = 5, OP_FLIP = 6, OP_SCORE = 7, OP_TURN = 8,
                 OP_HASCUR = 9, OP_HASOPP = 10, OP_REMOVE = 11, OP_MR = 12, OP_ML = 13,
                 OP_MU = 14, OP_MD = 15, OP_OVER = 16, OP_BAD = 99;

  logic clk = 1'b0, resetn = 1'b0;
  logic keyEnter = 0, keyRight = 0, keyLeft = 0, keyUp = 0, keyDown = 0;
  logic go = 0, validMove = 0, hasTurn = 0;
  logic resetEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn, checkIfValidMoveEn;
  logic placeEn, flipEn, scoreManagerEn, determineHasTurnEn, TurnManagerEn;
  logic removeHighlightEn, moveRightEn, moveLeftEn, moveUpEn, moveDownEn;
  logic determineCurrent, determineOpponent, gameOver;
  logic [4:0] stateOut;

  int n_vec = 0, n_err = 0;

  reversi_sequencer #(.TIMEOUT_CYCLES(32'd20)) dut (
    .clk(clk), .resetn(resetn),
    .keyEnter(keyEnter), .keyRight(keyRight), .keyLeft(keyLeft), .keyUp(keyUp), .keyDown(keyDown),
    .go(go), .validMove(validMove), .hasTurn(hasTurn),
    .resetEn(resetEn), .drawBoardEn(drawBoardEn), .drawInitialPiecesEn(drawInitialPiecesEn),
    .moveHighlightEn(moveHighlightEn), .checkIfValidMoveEn(checkIfValidMoveEn),
    .placeEn(placeEn), .flipEn(flipEn), .scoreManagerEn(scoreManagerEn),
    .determineHasTurnEn(determineHasTurnEn), .TurnManagerEn(TurnManagerEn),
    .removeHighlightEn(removeHighlightEn), .moveRightEn(moveRightEn), .moveLeftEn(moveLeftEn),
    .moveUpEn(moveUpEn), .moveDownEn(moveDownEn), .determineCurrent(determineCurrent),
    .determineOpponent(determineOpponent), .gameOver(gameOver), .stateOut(stateOut)
  );

  always #5 clk = ~clk;

  // Which single operation the outputs currently express; OP_BAD if the
  // outputs are not a legal one-hot pattern.
  function automatic int op();
    logic [15:0] v;
    v = {resetEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn, checkIfValidMoveEn,
         placeEn, flipEn, scoreManagerEn, determineHasTurnEn, TurnManagerEn,
         removeHighlightEn, moveRightEn, moveLeftEn, moveUpEn, moveDownEn, gameOver};
    if ($countones(v) > 1) return OP_BAD;
    if (determineHasTurnEn) begin
      if (determineCurrent && !determineOpponent) return OP_HASCUR;
      if (!determineCurrent && determineOpponent) return OP_HASOPP;
      return OP_BAD;
    end
    if (determineCurrent || determineOpponent) return OP_BAD;
    if (resetEn)             return OP_RST;
    if (drawBoardEn)         return OP_BOARD;
    if (drawInitialPiecesEn) return OP_PIECES;
    if (moveHighlightEn)     return OP_HL;
    if (checkIfValidMoveEn)  return OP_CHECK;
    if (placeEn)             return OP_PLACE;
    if (flipEn)              return OP_FLIP;
    if (scoreManagerEn)      return OP_SCORE;
    if (TurnManagerEn)       return OP_TURN;
    if (removeHighlightEn)   return OP_REMOVE;
    if (moveRightEn)         return OP_MR;
    if (moveLeftEn)          return OP_ML;
    if (moveUpEn)            return OP_MU;
    if (moveDownEn)          return OP_MD;
    if (gameOver)            return OP_OVER;
    return OP_NONE;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Datapath side of one wait state: expect op on entry, stay for d more
  // cycles (d >= 1), then answer go with the given results.
  task automatic step(input int exp, input int d, input logic vm, input logic ht);
    chk("entry", op(), exp);
    repeat (d) begin
      @(negedge clk);
      chk("dwell", op(), exp);
    end
    go = 1'b1; validMove = vm; hasTurn = ht;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic init();
    {keyEnter, keyRight, keyLeft, keyUp, keyDown} = '0;
    go = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    chk("reset_op", op(), OP_RST);
    resetn = 1'b1;
    @(negedge clk);
    step(OP_RST, 2, 0, 0);
    step(OP_BOARD, 2, 0, 0);
    step(OP_PIECES, 2, 0, 0);
    step(OP_HL, 2, 0, 0);
    chk("init_idle", op(), OP_NONE);
  endtask

  // dirs = {down, up, left, right}; priority Right > Left > Up > Down.
  task automatic move(input logic [3:0] dirs);
    int exp;
    exp = dirs[0] ? OP_MR : dirs[1] ? OP_ML : dirs[2] ? OP_MU : OP_MD;
    {keyDown, keyUp, keyLeft, keyRight} = dirs;
    @(negedge clk);
    chk("move_strobe", op(), exp);
    {keyDown, keyUp, keyLeft, keyRight} = '0;
    @(negedge clk);
    step(OP_HL, $urandom_range(1, 3), 0, 0);
    chk("move_idle", op(), OP_NONE);
  endtask

  // Press Enter (optionally with directions, which Enter outranks).
  task automatic enter(input logic [3:0] dirs, input logic vm);
    keyEnter = 1'b1;
    {keyDown, keyUp, keyLeft, keyRight} = dirs;
    @(negedge clk);
    {keyEnter, keyDown, keyUp, keyLeft, keyRight} = '0;
    step(OP_CHECK, $urandom_range(1, 3), vm, 0);
    if (!vm) chk("invalid_idle", op(), OP_NONE);
  endtask

  task automatic place_to_turn();
    step(OP_PLACE, $urandom_range(1, 3), 0, 0);
    step(OP_FLIP, $urandom_range(1, 3), 0, 0);
    step(OP_SCORE, $urandom_range(1, 3), 0, 0);
    step(OP_TURN, $urandom_range(1, 3), 0, 0);
  endtask

  // Has-turn resolution; over=1 when the game ends.
  task automatic turn_flow(input logic ht_cur, input logic ht_opp, output bit over);
    over = 0;
    step(OP_HASCUR, $urandom_range(1, 3), 0, ht_cur);
    if (!ht_cur) begin
      step(OP_HASOPP, $urandom_range(1, 3), 0, ht_opp);
      if (ht_opp) begin
        step(OP_TURN, $urandom_range(1, 3), 0, 0);
        step(OP_HASCUR, $urandom_range(1, 3), 0, 1'b1);
      end else begin
        step(OP_REMOVE, $urandom_range(1, 3), 0, 0);
        chk("over", op(), OP_OVER);
        over = 1;
        return;
      end
    end
    step(OP_HL, $urandom_range(1, 3), 0, 0);
    chk("turn_idle", op(), OP_NONE);
  endtask

  initial begin
    bit over;
    init();

    // Right and Up together: only Right moves.
    move(4'b0101);
    // Invalid placement returns to idle.
    enter(4'b0000, 1'b0);
    // Valid placement with a pass, then current player moves.
    enter(4'b0010, 1'b1);
    place_to_turn();
    turn_flow(1'b0, 1'b1, over);

    // go held high into the next state is ignored on its entry cycle.
    enter(4'b0000, 1'b1);
    chk("held_place", op(), OP_PLACE);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    chk("held_flip_entry", op(), OP_FLIP);
    @(negedge clk);
    chk("held_go_ignored", op(), OP_FLIP);
    go = 1'b0;
    // Asynchronous reset during S_FLIP.
    #2 resetn = 1'b0;
    #1 chk("async_reset", op(), OP_RST);
    init();

    // Game over, held against Enter.
    enter(4'b0000, 1'b1);
    place_to_turn();
    turn_flow(1'b0, 1'b0, over);
    keyEnter = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("over_held", op(), OP_OVER);
    end
    keyEnter = 1'b0;
    init();

`ifdef MOVE_TIMEOUT_EN
    // Idle for 20 cycles forfeits the turn.
    repeat (19) @(negedge clk);
    chk("tmo_before", op(), OP_NONE);
    @(negedge clk);
    chk("tmo_turn", op(), OP_TURN);
    step(OP_TURN, 1, 0, 0);
    turn_flow(1'b1, 1'b0, over);
    // Key edge in the expiry cycle wins and restarts the count.
    repeat (19) @(negedge clk);
    keyLeft = 1'b1;
    @(negedge clk);
    chk("tmo_key_wins", op(), OP_ML);
    keyLeft = 1'b0;
    @(negedge clk);
    step(OP_HL, 1, 0, 0);
    repeat (19) @(negedge clk);
    chk("tmo_cleared", op(), OP_NONE);
    @(negedge clk);
    chk("tmo_turn2", op(), OP_TURN);
    step(OP_TURN, 1, 0, 0);
    turn_flow(1'b1, 1'b0, over);
`endif

    // Randomized play.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: move(4'($urandom_range(1, 15)));
        1: enter(4'($urandom_range(0, 15)), 1'b0);
        default: begin
          enter(4'($urandom_range(0, 15)), 1'b1);
          place_to_turn();
          turn_flow($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, over);
          if (over) begin
            repeat (3) begin
              @(negedge clk);
              chk("rand_over", op(), OP_OVER);
            end
            init();
          end
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
